// File: rtl/vga_fc_pkg.sv
// Shared types and CRC constants for the VGA frame checker.
// The CRC feature is selected by VGA_FC_CRC_EN in the files that import this package.
package vga_fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_HS,
        SAMPLE,
        GAP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PIX_BG  = 2'd0,
        PIX_FG  = 2'd1,
        PIX_INV = 2'd2
    } pix_class_t;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/vga_crc_step.sv
// One combinational CRC-32 update over an RGB_W-bit sample, MSB first, no reflection.
// Instantiated by vga_frame_checker only when VGA_FC_CRC_EN is defined.
module vga_crc_step
    import vga_fc_pkg::*;
#(
    parameter int RGB_W = 8
) (
    input  logic [31:0]      crc_in,
    input  logic [RGB_W-1:0] data,
    output logic [31:0]      crc_out
);

    logic [31:0] chain [0:RGB_W];
    logic [RGB_W-1:0] fb;

    assign chain[0] = crc_in;

    for (genvar gi = 0; gi < RGB_W; gi++) begin : g_bit
        assign fb[gi]        = chain[gi][31] ^ data[RGB_W-1-gi];
        assign chain[gi+1]   = {chain[gi][30:0], 1'b0} ^ (fb[gi] ? CRC_POLY : 32'h0);
    end

    assign crc_out = chain[RGB_W];

endmodule

// File: rtl/vga_frame_checker.sv
// Captures sync-aligned VGA frames, classifies each sample and reports per-frame totals.
// Define VGA_FC_CRC_EN to add a CRC-32 signature of every captured frame on frame_crc.
module vga_frame_checker
    import vga_fc_pkg::*;
#(
    parameter int               CLK_PER_PIX = 2,
    parameter int               H_SAMPLES   = 705,
    parameter int               V_LINES     = 520,
    parameter int               RGB_W       = 8,
    parameter logic [RGB_W-1:0] BG_CODE     = RGB_W'(8'h00),
    parameter logic [RGB_W-1:0] FG_CODE     = RGB_W'(8'h1C)
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   start,
    input  logic                                   cont,
    input  logic                                   HSYNC,
    input  logic                                   VSYNC,
    input  logic [RGB_W-1:0]                       RGB,
    output logic                                   busy,
    output logic                                   pix_valid,
    output logic [1:0]                             pix_class,
    output logic [$clog2(H_SAMPLES)-1:0]           pix_x,
    output logic [$clog2(V_LINES)-1:0]             pix_y,
    output logic                                   frame_done,
    output logic [$clog2(H_SAMPLES*V_LINES+1)-1:0] fg_count,
    output logic [$clog2(H_SAMPLES*V_LINES+1)-1:0] inv_count,
    output logic [$clog2(V_LINES+1)-1:0]           lines_seen,
    output logic                                   frame_err,
    output logic                                   line_err,
    output logic [31:0]                            frame_crc
);

    localparam int XW = $clog2(H_SAMPLES);
    localparam int YW = $clog2(V_LINES);
    localparam int LW = $clog2(V_LINES + 1);
    localparam int CW = $clog2(H_SAMPLES * V_LINES + 1);
    localparam int PW = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;

    state_t     state_reg;
    logic       hs_prev_reg, vs_prev_reg, short_reg;
    logic [XW-1:0] x_reg, sx;
    logic [LW-1:0] y_reg;
    logic [PW-1:0] phase_reg;
    logic [CW-1:0] fg_reg, inv_reg;
    logic       take, abort, hs_rise, vs_rise, last_x, last_y, arm;
    pix_class_t cls;

`ifdef VGA_FC_CRC_EN
    logic [31:0] crc_reg, crc_next;

    vga_crc_step #(.RGB_W(RGB_W)) u_crc_step (
        .crc_in  (crc_reg),
        .data    (RGB),
        .crc_out (crc_next)
    );
`else
    assign frame_crc = 32'h0;
`endif

    assign hs_rise = HSYNC & ~hs_prev_reg;
    assign vs_rise = VSYNC & ~vs_prev_reg;
    assign arm     = ((state_reg == IDLE) && start) || ((state_reg == DONE) && cont);
    assign last_x  = (sx == XW'(H_SAMPLES - 1));
    assign last_y  = (y_reg == LW'(V_LINES - 1));

    // Decide whether this edge captures a sample; a VSYNC rise mid-frame wins over sampling.
    always_comb begin
        take  = 1'b0;
        abort = 1'b0;
        sx    = x_reg;
        case (state_reg)
            ARMED: begin
                if (VSYNC && HSYNC) begin
                    take = 1'b1;
                    sx   = '0;
                end
            end
            WAIT_HS: begin
                if (vs_rise) begin
                    abort = 1'b1;
                end else if (HSYNC) begin
                    take = 1'b1;
                    sx   = '0;
                end
            end
            GAP: begin
                if (vs_rise) begin
                    abort = 1'b1;
                end else if (hs_rise) begin
                    take = 1'b1;
                    sx   = '0;
                end
            end
            SAMPLE: begin
                if (vs_rise) begin
                    abort = 1'b1;
                end else if (phase_reg == '0) begin
                    take = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        if (RGB == BG_CODE) begin
            cls = PIX_BG;
        end else if (RGB == FG_CODE) begin
            cls = PIX_FG;
        end else begin
            cls = PIX_INV;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= IDLE;
            hs_prev_reg <= 1'b0;
            vs_prev_reg <= 1'b0;
            short_reg   <= 1'b0;
            x_reg       <= '0;
            y_reg       <= '0;
            phase_reg   <= '0;
            fg_reg      <= '0;
            inv_reg     <= '0;
            busy        <= 1'b0;
            pix_valid   <= 1'b0;
            pix_class   <= 2'd0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_done  <= 1'b0;
            fg_count    <= '0;
            inv_count   <= '0;
            lines_seen  <= '0;
            frame_err   <= 1'b0;
            line_err    <= 1'b0;
`ifdef VGA_FC_CRC_EN
            crc_reg     <= CRC_INIT;
            frame_crc   <= 32'h0;
`endif
        end else begin
            hs_prev_reg <= HSYNC;
            vs_prev_reg <= VSYNC;
            pix_valid   <= take;
            frame_done  <= 1'b0;

            if (state_reg == SAMPLE && hs_rise) begin
                line_err <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= ARMED;
                        busy      <= 1'b1;
                        line_err  <= 1'b0;
                    end
                end
                ARMED: begin
                    if (VSYNC && !HSYNC) begin
                        state_reg <= WAIT_HS;
                    end
                end
                SAMPLE: begin
                    if (!take) begin
                        phase_reg <= phase_reg - 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    fg_count   <= fg_reg;
                    inv_count  <= inv_reg;
                    lines_seen <= y_reg;
                    frame_err  <= short_reg;
`ifdef VGA_FC_CRC_EN
                    frame_crc  <= crc_reg;
`endif
                    state_reg  <= cont ? ARMED : IDLE;
                    busy       <= cont;
                end
                default: ;
            endcase

            if (abort) begin
                state_reg <= DONE;
                short_reg <= 1'b1;
            end else if (take) begin
                pix_class <= cls;
                pix_x     <= sx;
                pix_y     <= y_reg[YW-1:0];
                fg_reg    <= fg_reg + CW'(cls == PIX_FG);
                inv_reg   <= inv_reg + CW'(cls == PIX_INV);
`ifdef VGA_FC_CRC_EN
                crc_reg   <= crc_next;
`endif
                phase_reg <= PW'(CLK_PER_PIX - 1);
                if (last_x) begin
                    x_reg     <= '0;
                    y_reg     <= y_reg + 1'b1;
                    state_reg <= last_y ? DONE : GAP;
                end else begin
                    x_reg     <= sx + 1'b1;
                    state_reg <= SAMPLE;
                end
            end

            // Every new frame starts from clean running totals.
            if (arm) begin
                short_reg <= 1'b0;
                x_reg     <= '0;
                y_reg     <= '0;
                phase_reg <= '0;
                fg_reg    <= '0;
                inv_reg   <= '0;
`ifdef VGA_FC_CRC_EN
                crc_reg   <= CRC_INIT;
`endif
            end
        end
    end

endmodule

// File: doc/vga_frame_checker.md
# vga_frame_checker

Synthesisable VGA output checker. It sits beside the AHB-Lite system's VGA port (HSYNC, VSYNC, packed 8-bit RGB) and is used both in simulation benches and on-chip for self-test. From a start request it captures one frame of sync-aligned samples (or frames back-to-back) and classifies each sample as background, foreground or invalid. It streams the classified pixels with coordinates and produces per-frame counts, a sync-error flag and an optional CRC-32 signature.

## Interface
- CLK_PER_PIX, 2: CLK cycles between samples; must be ≥1.
- H_SAMPLES, 705: samples captured per line.
- V_LINES, 520: lines captured per frame.
- RGB_W, 8: RGB bus width.
- BG_CODE, 8'h00: RGB value classified as background.
- FG_CODE, 8'h1C: RGB value classified as foreground.
- CLK  in  1  system clock; all inputs are synchronous to it.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle arm request; ignored while busy.
- cont  in  1  continuous mode; sampled when DONE is reached.
- HSYNC  in  1  line sync, active high.
- VSYNC  in  1  frame sync, active high.
- RGB  in  RGB_W  pixel value.
- busy  out  1  high in every state except IDLE.
- pix_valid  out  1  one-cycle strobe per captured sample.
- pix_class  out  2  sample class: 0 = BG, 1 = FG, 2 = INVALID.
- pix_x  out  $clog2(H_SAMPLES)  sample index within the line, 0-based.
- pix_y  out  $clog2(V_LINES)  line index, 0-based.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- fg_count, inv_count  out  $clog2(H_SAMPLES*V_LINES+1)  per-frame totals.
- lines_seen  out  $clog2(V_LINES+1)  lines completed in the last frame.
- frame_err  out  1  last frame was short (see below).
- line_err  out  1  sticky overrun flag; cleared by start or RESET.
- frame_crc  out  32  signature of the last frame.

## Operation
- IDLE → ARMED on start.
- ARMED → SAMPLE on the first edge with VSYNC=1 and HSYNC=1.
- ARMED → WAIT_HS on the first edge with VSYNC=1 and HSYNC=0.
- WAIT_HS → SAMPLE on the first edge with HSYNC=1. The first sample is taken on that same edge.
- SAMPLE takes one sample every CLK_PER_PIX cycles, H_SAMPLES samples in total.
  - After the last sample, go to GAP. If this was line V_LINES-1, go to DONE instead.
- GAP → SAMPLE on a HSYNC rising edge (HSYNC was 0 on the previous edge). The first sample is taken on that edge.
- DONE lasts one cycle, then goes to ARMED if cont=1, otherwise to IDLE.
- Classification: RGB==BG_CODE gives BG, RGB==FG_CODE gives FG, anything else gives INVALID. BG_CODE has priority if the two codes are equal.
- Per frame:
  - fg_count and inv_count accumulate through the frame.
  - Internal counters clear on entry to ARMED.
  - The output registers update at DONE and hold until the next DONE.
- Overrun: a HSYNC rising edge during SAMPLE sets line_err. The line still completes normally.
- Short frame: a VSYNC rising edge in SAMPLE, WAIT_HS or GAP before the frame completes:
  - sets frame_err and forces DONE;
  - lines_seen reports the number of completed lines;
  - counts and CRC cover only the samples taken.
- A completed frame clears frame_err and sets lines_seen = V_LINES.
- Simultaneous start and DONE: start is ignored.
- RESET at any time returns to IDLE and clears the counters.

## Timing
- pix_valid, pix_class, pix_x and pix_y are registered: they appear one cycle after the sampling edge.
- frame_done and the updated totals appear one cycle after the final pix_valid.
- Reset values: all outputs 0. frame_crc resets to 32'h0; the running CRC initialises to 32'hFFFFFFFF on entry to ARMED.
- busy rises the cycle after start is accepted. It falls the cycle after DONE when cont=0.

## Configuration
- VGA_FC_CRC_EN defined:
  - CRC-32 runs over each sample's RGB_W bits, MSB first.
  - Polynomial 32'h04C11DB7, no reflection, no final XOR.
  - The running value is latched into frame_crc at DONE.
- VGA_FC_CRC_EN undefined: frame_crc is tied to 0 and no CRC logic is generated.

## Structure
- Package vga_fc_pkg holds:
  - the state enum (IDLE, ARMED, WAIT_HS, SAMPLE, GAP, DONE);
  - the pixel-class enum;
  - the CRC_POLY and CRC_INIT constants.
- Sub-module vga_crc_step: a combinational next-CRC function over RGB_W bits. It is instantiated only under VGA_FC_CRC_EN.

## Test plan
All scenarios use H_SAMPLES=4, V_LINES=3, CLK_PER_PIX=2 unless stated.
- Reset: assert RESET mid-SAMPLE → next edge has busy=0 and every output 0; a new start captures normally.
- Full frame: RGB pattern {00,1C,00,1C} on every line → 12 pix_valid pulses, fg_count=6, inv_count=0, lines_seen=3, frame_done once, frame_err=0.
- Invalid pixels: RGB=8'hFF on sample x=2 of every line → pix_class=2 at x=2, inv_count=3.
- Short frame: VSYNC rising edge after line 1 → frame_done, frame_err=1, lines_seen=1, fg_count covers only 4 samples.
- Overrun: HSYNC pulse 3 cycles into a line → line_err=1 and remains set after frame_done.
- Continuous mode: cont=1 with two frames → two frame_done pulses, busy stays high between them. With VGA_FC_CRC_EN defined, both frame_crc values equal the reference-model CRC of the 12 samples.
